regfile_read_ctrl: RTL and testbench
====================================

# regfile_read_ctrl

Initiator-side controller for the dual-read, single-write register file: accepts operand-fetch requests from decode, drives the register file's read enables and addresses, absorbs its one-cycle registered read latency, and returns both operands on a valid/ready handshake. It forwards writeback data that the block-RAM register file cannot return in the same cycle. A debug dump mode streams all registers out sequentially.

## Interface
- XLEN, 32, register data width
- REG_AW, 5, register address width; NUM_REGS = 2**REG_AW
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  operand fetch request
- req_ready  out  1  request accepted when valid && ready
- req_rs1, req_rs2  in  REG_AW  source register indices
- op_valid  out  1  operands available
- op_ready  in  1  consumer accepts operands
- op_rs1_data, op_rs2_data  out  XLEN  operand values
- wb_en  in  1  writeback strobe
- wb_reg  in  REG_AW  writeback index
- wb_data  in  XLEN  writeback value
- rf_rd_1_en, rf_rd_2_en  out  1  register file read enables
- rf_read_reg_1, rf_read_reg_2  out  REG_AW  read addresses
- rf_write_en  out  1  equals wb_en
- rf_write_reg  out  REG_AW  equals wb_reg
- rf_write_data  out  XLEN  equals wb_data
- rf_data_out_1, rf_data_out_2  in  XLEN  registered read data (valid the cycle after enable)
- dump_start  in  1  start register dump (sampled in IDLE only)
- dump_busy  out  1  dump in progress
- dump_valid  out  1  dump_data/dump_idx valid this cycle
- dump_idx  out  REG_AW  register index of dump_data
- dump_data  out  XLEN  register value

## Operation
- States: IDLE, FETCH, HOLD, DUMP.
- IDLE: req_ready=1. On req_valid: assert rf_rd_1_en/rf_rd_2_en with addresses req_rs1/req_rs2 combinationally, latch indices, go FETCH. Otherwise, on dump_start: go DUMP, idx=0. A request has priority over dump_start in the same cycle.
- FETCH: capture operands into output registers, go HOLD. Per operand, the captured value is selected by priority: index 0 -> 0; wb hit this cycle -> wb_data; wb hit in the issue cycle -> its wb_data; otherwise rf_data_out.
- HOLD: op_valid=1. On op_ready go IDLE. A wb hit on a held non-zero index overwrites that operand register at the same edge.
- DUMP: each cycle issue a port-1 read of idx and increment. dump_valid follows one cycle later with dump_idx=k. Reg 0 reads as 0. The same wb bypass applies as in FETCH. dump_busy is high from entry until the cycle after idx 31 is emitted, then the block returns to IDLE. There is no backpressure. req_ready=0 during DUMP.
- Read enables are low in every cycle that issues no read.
- Writes to index 0 pass to the register file unchanged and are never forwarded.
- The write port is a pure pass-through, active in all states.

## Timing
- Reset values: state IDLE, req_ready=1 (combinational from IDLE), op_valid=0, op data 0, dump_valid=0, dump_busy=0, dump_idx=0, dump_data=0, read enables 0.
- Reset mid-operation aborts any fetch or dump. Register file contents are untouched.
- Latency: request accepted at edge T -> op_valid high in cycle T+2.
- Minimum request interval: 3 cycles (accept, FETCH, HOLD with op_ready=1).
- Dump: 32 valid beats in consecutive cycles, first beat 2 cycles after dump_start is accepted.
- op outputs are stable while op_valid && !op_ready, except for wb bypass updates.
- Same-cycle write and read to the same index never returns stale data.

## Structure
- regfile_pkg: XLEN, REG_AW, NUM_REGS, state enum.
- Sub-module regfile_bypass: per-operand compare-and-select (index, wb_en, wb_reg, wb_data, pending bypass, rf data -> value). Instantiated twice in the fetch path and reused in the dump path.

## Test plan
- Preload x5=0x11, x6=0x22. Request rs1=5, rs2=6 -> op_valid at T+2 with 0x11/0x22. Read enables high only in cycle T.
- Request rs1=5 with wb_en, wb_reg=5, wb_data=0xAA in the issue cycle -> op_rs1_data=0xAA. Repeat with the write in the FETCH cycle -> 0xAA.
- Hold op_ready=0 for 4 cycles, then write x6=0x33 -> op_rs2_data becomes 0x33 next cycle. Outputs are otherwise stable.
- Request rs1=0 while writing reg 0 with 0xFF -> op_rs1_data=0, and rf_write_en still passes through.
- Fill xk=k+0x100 and pulse dump_start -> 32 consecutive beats, idx 0..31, data 0 then 0x101..0x11F. req_ready=0 throughout.
- Assert reset during HOLD and during dump beat 10 -> all outputs at reset values immediately. A new request then completes normally.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared parameters, FSM state encoding and the write-forwarding hit test
// for the register file read controller.
package regfile_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 2 ** REG_AW;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD,
    ST_DUMP
  } state_e;

  // A writeback only forwards to a reader of the same, non-zero index;
  // register 0 is hardwired to zero no matter what gets written to it.
  function automatic logic wb_hit(input logic             en,
                                  input logic [REG_AW-1:0] wreg,
                                  input logic [REG_AW-1:0] idx);
    return en && (wreg == idx) && (idx != '0);
  endfunction

endpackage

// File: rtl/regfile_read_ctrl_if.sv
// Operand-fetch handshake between decode (master) and the read controller
// (slave): request channel with two source indices, response channel with
// both operand values.
interface regfile_read_ctrl_if;
  import regfile_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [REG_AW-1:0] req_rs1;
  logic [REG_AW-1:0] req_rs2;
  logic              op_valid;
  logic              op_ready;
  logic [XLEN-1:0]   op_rs1_data;
  logic [XLEN-1:0]   op_rs2_data;

  modport master (
    output req_valid, req_rs1, req_rs2, op_ready,
    input  req_ready, op_valid, op_rs1_data, op_rs2_data
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2, op_ready,
    output req_ready, op_valid, op_rs1_data, op_rs2_data
  );

endinterface

// File: rtl/regfile_bypass.sv
// Per-operand value select: zero register, then a writeback landing this
// cycle, then a writeback remembered from the issue cycle, else the value
// the register file returned.
module regfile_bypass
  import regfile_pkg::*;
(
  input  logic [REG_AW-1:0] idx,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              pend_valid,
  input  logic [XLEN-1:0]   pend_data,
  input  logic [XLEN-1:0]   rf_data,
  output logic [XLEN-1:0]   value
);

  // Newest data wins; the registered read cannot see either writeback.
  always_comb begin
    value = rf_data;
    if (idx == '0)
      value = '0;
    else if (wb_hit(wb_en, wb_reg, idx))
      value = wb_data;
    else if (pend_valid)
      value = pend_data;
  end

endmodule

// File: rtl/regfile_read_ctrl.sv
// Operand-fetch controller in front of a block-RAM register file with a
// one-cycle registered read. Issues both reads on request acceptance,
// captures the results with writeback forwarding, holds them on a
// valid/ready handshake, and can stream every register out in dump mode.
module regfile_read_ctrl
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  regfile_read_ctrl_if.slave  bus,
  input  logic                wb_en,
  input  logic [REG_AW-1:0]   wb_reg,
  input  logic [XLEN-1:0]     wb_data,
  output logic                rf_rd_1_en,
  output logic                rf_rd_2_en,
  output logic [REG_AW-1:0]   rf_read_reg_1,
  output logic [REG_AW-1:0]   rf_read_reg_2,
  output logic                rf_write_en,
  output logic [REG_AW-1:0]   rf_write_reg,
  output logic [XLEN-1:0]     rf_write_data,
  input  logic [XLEN-1:0]     rf_data_out_1,
  input  logic [XLEN-1:0]     rf_data_out_2,
  input  logic                dump_start,
  output logic                dump_busy,
  output logic                dump_valid,
  output logic [REG_AW-1:0]   dump_idx,
  output logic [XLEN-1:0]     dump_data
);

  state_e            state_q;
  logic [REG_AW-1:0] rs1_q, rs2_q;
  logic              pend1_q, pend2_q;
  logic [XLEN-1:0]   pend1_data_q, pend2_data_q;
  logic [XLEN-1:0]   op1_q, op2_q;
  logic [REG_AW-1:0] dump_ptr_q;
  logic              issue_done_q;
  logic              beat_q;
  logic [XLEN-1:0]   byp1, byp2;
  logic              accept;
  logic              dump_issue;

  assign accept     = (state_q == ST_IDLE) && bus.req_valid;
  assign dump_issue = (state_q == ST_DUMP) && !issue_done_q;

  assign bus.req_ready   = (state_q == ST_IDLE);
  assign bus.op_valid    = (state_q == ST_HOLD);
  assign bus.op_rs1_data = op1_q;
  assign bus.op_rs2_data = op2_q;

  assign rf_rd_1_en    = accept || dump_issue;
  assign rf_rd_2_en    = accept;
  assign rf_read_reg_1 = dump_issue ? dump_ptr_q : bus.req_rs1;
  assign rf_read_reg_2 = bus.req_rs2;

  assign rf_write_en   = wb_en;
  assign rf_write_reg  = wb_reg;
  assign rf_write_data = wb_data;

  // The dump beat is the cycle the registered read data arrives, so its
  // value comes straight from the port-1 bypass rather than a register.
  assign dump_busy  = (state_q == ST_DUMP);
  assign dump_valid = beat_q;
  assign dump_idx   = beat_q ? rs1_q : '0;
  assign dump_data  = beat_q ? byp1 : '0;

  regfile_bypass u_byp1 (
    .idx        (rs1_q),
    .wb_en      (wb_en),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data),
    .pend_valid (pend1_q),
    .pend_data  (pend1_data_q),
    .rf_data    (rf_data_out_1),
    .value      (byp1)
  );

  regfile_bypass u_byp2 (
    .idx        (rs2_q),
    .wb_en      (wb_en),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data),
    .pend_valid (pend2_q),
    .pend_data  (pend2_data_q),
    .rf_data    (rf_data_out_2),
    .value      (byp2)
  );

  // Control FSM; in dump mode rs1_q/pend1_q track the index in flight so
  // the fetch-path bypass on port 1 serves the dump stream as well.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rs1_q        <= '0;
      rs2_q        <= '0;
      pend1_q      <= 1'b0;
      pend2_q      <= 1'b0;
      pend1_data_q <= '0;
      pend2_data_q <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      dump_ptr_q   <= '0;
      issue_done_q <= 1'b0;
      beat_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            rs1_q        <= bus.req_rs1;
            rs2_q        <= bus.req_rs2;
            pend1_q      <= wb_hit(wb_en, wb_reg, bus.req_rs1);
            pend2_q      <= wb_hit(wb_en, wb_reg, bus.req_rs2);
            pend1_data_q <= wb_data;
            pend2_data_q <= wb_data;
            state_q      <= ST_FETCH;
          end else if (dump_start) begin
            dump_ptr_q   <= '0;
            issue_done_q <= 1'b0;
            beat_q       <= 1'b0;
            state_q      <= ST_DUMP;
          end
        end
        ST_FETCH: begin
          op1_q   <= byp1;
          op2_q   <= byp2;
          state_q <= ST_HOLD;
        end
        ST_HOLD: begin
          if (wb_hit(wb_en, wb_reg, rs1_q)) op1_q <= wb_data;
          if (wb_hit(wb_en, wb_reg, rs2_q)) op2_q <= wb_data;
          if (bus.op_ready) state_q <= ST_IDLE;
        end
        ST_DUMP: begin
          if (!issue_done_q) begin
            rs1_q        <= dump_ptr_q;
            pend1_q      <= wb_hit(wb_en, wb_reg, dump_ptr_q);
            pend1_data_q <= wb_data;
            beat_q       <= 1'b1;
            if (dump_ptr_q == REG_AW'(NUM_REGS - 1))
              issue_done_q <= 1'b1;
            else
              dump_ptr_q <= dump_ptr_q + 1'b1;
          end else begin
            beat_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_read_ctrl.sv
// Directed bench for regfile_read_ctrl with a behavioural block-RAM
// register file (read-before-write, one-cycle registered read).
module tb_regfile_read_ctrl;
  import regfile_pkg::*;

  logic              clk;
  logic              reset;
  logic              wb_en;
  logic [REG_AW-1:0] wb_reg;
  logic [XLEN-1:0]   wb_data;
  logic              rf_rd_1_en, rf_rd_2_en;
  logic [REG_AW-1:0] rf_read_reg_1, rf_read_reg_2;
  logic              rf_write_en;
  logic [REG_AW-1:0] rf_write_reg;
  logic [XLEN-1:0]   rf_write_data;
  logic [XLEN-1:0]   rf_data_out_1, rf_data_out_2;
  logic              dump_start;
  logic              dump_busy, dump_valid;
  logic [REG_AW-1:0] dump_idx;
  logic [XLEN-1:0]   dump_data;

  logic [XLEN-1:0]   rf_mem [NUM_REGS];

  int err_cnt = 0;
  int chk_cnt = 0;

  regfile_read_ctrl_if bus ();

  regfile_read_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .wb_en         (wb_en),
    .wb_reg        (wb_reg),
    .wb_data       (wb_data),
    .rf_rd_1_en    (rf_rd_1_en),
    .rf_rd_2_en    (rf_rd_2_en),
    .rf_read_reg_1 (rf_read_reg_1),
    .rf_read_reg_2 (rf_read_reg_2),
    .rf_write_en   (rf_write_en),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .rf_data_out_1 (rf_data_out_1),
    .rf_data_out_2 (rf_data_out_2),
    .dump_start    (dump_start),
    .dump_busy     (dump_busy),
    .dump_valid    (dump_valid),
    .dump_idx      (dump_idx),
    .dump_data     (dump_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: reads return the pre-write contents.
  always @(posedge clk) begin
    if (rf_write_en) rf_mem[rf_write_reg] <= rf_write_data;
    if (rf_rd_1_en)  rf_data_out_1 <= rf_mem[rf_read_reg_1];
    if (rf_rd_2_en)  rf_data_out_2 <= rf_mem[rf_read_reg_2];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    chk_cnt++;
    if (actual !== expected) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [4:0] r1,
                               input logic [4:0] r2, input logic ordy,
                               input logic we, input logic [4:0] wr,
                               input logic [31:0] wd, input logic ds);
    bus.req_valid = rv;
    bus.req_rs1   = r1;
    bus.req_rs2   = r2;
    bus.op_ready  = ordy;
    wb_en         = we;
    wb_reg        = wr;
    wb_data       = wd;
    dump_start    = ds;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
  endtask

  task automatic releaseOp();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    idle();
  endtask

  initial begin
    logic [31:0] exp;
    for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = '0;
    rf_data_out_1 = '0;
    rf_data_out_2 = '0;
    reset = 1'b1;
    idle();
    #2;
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'h1);
    checkOutput("rst_op_valid", 32'(bus.op_valid), 32'h0);
    checkOutput("rst_op1", bus.op_rs1_data, 32'h0);
    checkOutput("rst_op2", bus.op_rs2_data, 32'h0);
    checkOutput("rst_dump_valid", 32'(dump_valid), 32'h0);
    checkOutput("rst_dump_busy", 32'(dump_busy), 32'h0);
    checkOutput("rst_dump_idx", 32'(dump_idx), 32'h0);
    checkOutput("rst_dump_data", dump_data, 32'h0);
    checkOutput("rst_rd1_en", 32'(rf_rd_1_en), 32'h0);
    checkOutput("rst_rd2_en", 32'(rf_rd_2_en), 32'h0);
    #10 reset = 1'b0;
    tick();

    // Preload x5 and x6 through the write pass-through
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd5, 32'h11, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd6, 32'h22, 1'b0);
    tick();
    idle();
    tick();

    // Plain fetch: reads only in the issue cycle, operands at T+2
    applyStimulus(1'b1, 5'd5, 5'd6, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    checkOutput("issue_req_ready", 32'(bus.req_ready), 32'h1);
    checkOutput("issue_rd1_en", 32'(rf_rd_1_en), 32'h1);
    checkOutput("issue_rd2_en", 32'(rf_rd_2_en), 32'h1);
    checkOutput("issue_addr1", 32'(rf_read_reg_1), 32'd5);
    checkOutput("issue_addr2", 32'(rf_read_reg_2), 32'd6);
    tick();
    idle();
    #1;
    checkOutput("fetch_rd1_en", 32'(rf_rd_1_en), 32'h0);
    checkOutput("fetch_rd2_en", 32'(rf_rd_2_en), 32'h0);
    checkOutput("fetch_op_valid", 32'(bus.op_valid), 32'h0);
    tick();
    checkOutput("hold_op_valid", 32'(bus.op_valid), 32'h1);
    checkOutput("hold_op1", bus.op_rs1_data, 32'h11);
    checkOutput("hold_op2", bus.op_rs2_data, 32'h22);
    checkOutput("hold_req_ready", 32'(bus.req_ready), 32'h0);
    checkOutput("hold_rd1_en", 32'(rf_rd_1_en), 32'h0);
    releaseOp();
    #1;
    checkOutput("done_op_valid", 32'(bus.op_valid), 32'h0);
    checkOutput("done_req_ready", 32'(bus.req_ready), 32'h1);

    // Write x5 in the issue cycle, read it on both ports
    applyStimulus(1'b1, 5'd5, 5'd5, 1'b0, 1'b1, 5'd5, 32'hAA, 1'b0);
    tick();
    idle();
    tick();
    checkOutput("byp_issue_op1", bus.op_rs1_data, 32'hAA);
    checkOutput("byp_issue_op2", bus.op_rs2_data, 32'hAA);
    releaseOp();

    // Write x6 in the FETCH cycle
    applyStimulus(1'b1, 5'd6, 5'd5, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd6, 32'hCC, 1'b0);
    tick();
    idle();
    checkOutput("byp_fetch_op1", bus.op_rs1_data, 32'hCC);
    checkOutput("byp_fetch_op2", bus.op_rs2_data, 32'hAA);
    releaseOp();

    // Backpressure for 4 cycles, then a writeback into a held operand
    applyStimulus(1'b1, 5'd5, 5'd6, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    idle();
    tick();
    for (int c = 0; c < 4; c++) begin
      checkOutput("stall_op_valid", 32'(bus.op_valid), 32'h1);
      checkOutput("stall_op1", bus.op_rs1_data, 32'hAA);
      checkOutput("stall_op2", bus.op_rs2_data, 32'hCC);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd6, 32'h33, 1'b0);
    #1;
    checkOutput("hold_wb_before", bus.op_rs2_data, 32'hCC);
    tick();
    idle();
    checkOutput("hold_wb_op2", bus.op_rs2_data, 32'h33);
    checkOutput("hold_wb_op1", bus.op_rs1_data, 32'hAA);
    checkOutput("hold_wb_valid", 32'(bus.op_valid), 32'h1);
    releaseOp();

    // Writes to x0 reach the register file but are never forwarded
    applyStimulus(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 5'd0, 32'hFF, 1'b0);
    #1;
    checkOutput("x0_wr_en", 32'(rf_write_en), 32'h1);
    checkOutput("x0_wr_reg", 32'(rf_write_reg), 32'h0);
    checkOutput("x0_wr_data", rf_write_data, 32'hFF);
    tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 32'hFE, 1'b0);
    tick();
    idle();
    checkOutput("x0_op1", bus.op_rs1_data, 32'h0);
    checkOutput("x0_op2", bus.op_rs2_data, 32'hAA);
    releaseOp();

    // Fill xk = k + 0x100 (x0 included; it must still dump as 0)
    for (int k = 0; k < NUM_REGS; k++) begin
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'(k), 32'h100 + 32'(k), 1'b0);
      tick();
    end
    idle();
    tick();

    // Full dump with a pending-path hit on x20 and a same-cycle hit on x25
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    tick();
    idle();
    #1;
    checkOutput("dump_entry_busy", 32'(dump_busy), 32'h1);
    checkOutput("dump_entry_ready", 32'(bus.req_ready), 32'h0);
    checkOutput("dump_entry_valid", 32'(dump_valid), 32'h0);
    checkOutput("dump_entry_rd1", 32'(rf_rd_1_en), 32'h1);
    checkOutput("dump_entry_addr", 32'(rf_read_reg_1), 32'h0);
    for (int k = 0; k < NUM_REGS; k++) begin
      if (k == 20) applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd20, 32'h555, 1'b0);
      else idle();
      tick();
      if (k == 25) applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd25, 32'h666, 1'b0);
      else idle();
      #1;
      if (k == 0) exp = 32'h0;
      else if (k == 20) exp = 32'h555;
      else if (k == 25) exp = 32'h666;
      else exp = 32'h100 + 32'(k);
      checkOutput("dump_valid", 32'(dump_valid), 32'h1);
      checkOutput("dump_idx", 32'(dump_idx), 32'(k));
      checkOutput("dump_data", dump_data, exp);
      checkOutput("dump_req_ready", 32'(bus.req_ready), 32'h0);
      checkOutput("dump_busy", 32'(dump_busy), 32'h1);
    end
    idle();
    tick();
    checkOutput("dump_end_valid", 32'(dump_valid), 32'h0);
    checkOutput("dump_end_busy", 32'(dump_busy), 32'h0);
    checkOutput("dump_end_ready", 32'(bus.req_ready), 32'h1);
    checkOutput("dump_end_rd1", 32'(rf_rd_1_en), 32'h0);

    // Reset while holding operands
    applyStimulus(1'b1, 5'd7, 5'd8, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    idle();
    tick();
    checkOutput("pre_rst_op_valid", 32'(bus.op_valid), 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("rst_hold_op_valid", 32'(bus.op_valid), 32'h0);
    checkOutput("rst_hold_op1", bus.op_rs1_data, 32'h0);
    checkOutput("rst_hold_op2", bus.op_rs2_data, 32'h0);
    checkOutput("rst_hold_ready", 32'(bus.req_ready), 32'h1);
    #2 reset = 1'b0;
    tick();

    // Reset during dump beat 10
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    tick();
    idle();
    for (int c = 0; c < 11; c++) tick();
    checkOutput("pre_rst_dump_idx", 32'(dump_idx), 32'd10);
    reset = 1'b1;
    #1;
    checkOutput("rst_dump_valid2", 32'(dump_valid), 32'h0);
    checkOutput("rst_dump_busy2", 32'(dump_busy), 32'h0);
    checkOutput("rst_dump_idx2", 32'(dump_idx), 32'h0);
    checkOutput("rst_dump_data2", dump_data, 32'h0);
    checkOutput("rst_dump_rd1", 32'(rf_rd_1_en), 32'h0);
    checkOutput("rst_dump_ready", 32'(bus.req_ready), 32'h1);
    #2 reset = 1'b0;
    tick();

    // A fresh request completes normally after the reset
    applyStimulus(1'b1, 5'd7, 5'd8, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    idle();
    tick();
    checkOutput("post_rst_valid", 32'(bus.op_valid), 32'h1);
    checkOutput("post_rst_op1", bus.op_rs1_data, 32'h107);
    checkOutput("post_rst_op2", bus.op_rs2_data, 32'h108);
    releaseOp();
    #1;
    checkOutput("post_rst_done", 32'(bus.op_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
